tinyalu_cmd_sequencer: RTL and testbench
========================================

# tinyalu_cmd_sequencer

Synthesizable command sequencer that sits directly upstream of the tinyALU core. It accepts operation commands over a valid/ready stream, buffers them in a small FIFO, and drives the ALU's start/op/A/B/C pins. It holds those pins per the ALU start/done protocol, captures each 16-bit result, and returns it over a valid/ready response stream. It also contains a done-watchdog and rejects illegal opcodes.

## Interface
- DEPTH, 4: command FIFO depth; power of two, ≥2
- TIMEOUT, 255: maximum cycles in WAIT before abandoning a command; 1..65535
- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept; = !full && !reset
- cmd_op  in  3  000 no_op, 001 add, 010 and, 011 xor, 100 mul, 101 or, 110 mad, 111 illegal
- cmd_a, cmd_b, cmd_c  in  8 each  operands (C used by mad only)
- alu_start  out  1  ALU start
- alu_op  out  3  ALU op bus
- alu_a, alu_b, alu_c  out  8 each  ALU operands
- alu_done  in  1  ALU done
- alu_result  in  16  ALU result
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  16  captured result; 0 on error
- rsp_op  out  3  opcode of the command answered
- rsp_status  out  2  00 ok, 01 timeout, 10 illegal op
- fifo_level  out  $clog2(DEPTH+1)  commands buffered (excluding the one in flight)

## Operation
- FIFO push on posedge when cmd_valid && cmd_ready. Pop happens only from IDLE. Commands issue strictly in arrival order.
- FSM states are IDLE, NOP, WAIT, RESP.
- IDLE with FIFO non-empty: pop the head, register alu_op/a/b/c.
  - Op 000 → NOP with alu_start=1.
  - Op 001–110 → WAIT with alu_start=1, watchdog count=0.
  - Op 111 → RESP with rsp_status=10, rsp_result=0. alu_start is never asserted.
- NOP: next edge alu_start←0, → IDLE. No response is generated for no_op.
- WAIT: alu_start and operands stay stable every cycle.
  - If alu_done is sampled 1: rsp_result←alu_result, rsp_status←00, alu_start←0, → RESP.
  - Else if count == TIMEOUT-1: rsp_result←0, rsp_status←01, alu_start←0, → RESP.
  - Else count+1.
  - Done wins over timeout when both occur in the same cycle.
- RESP: rsp_valid=1. rsp_result/op/status are stable until the handshake. On rsp_valid && rsp_ready → IDLE.
- alu_op/a/b/c hold their last values when alu_start=0.
- Result width: ALU result passes unmodified, 16 bits. The block performs no arithmetic on data.
- fifo_level: +1 on push, −1 on pop, unchanged on simultaneous push and pop.

## Timing
- Reset values:
  - alu_start=0, alu_op=000, alu_a/b/c=0
  - rsp_valid=0, rsp_result=0, rsp_op=000, rsp_status=00
  - fifo_level=0, cmd_ready=0 while reset=1
  - FSM=IDLE, watchdog=0
- Reset mid-operation: in-flight command and FIFO contents are discarded. alu_start is 0 from the edge where reset is sampled. No response is emitted.
- Command accepted at edge E0 into an empty FIFO in IDLE → alu_start=1 after E1 (1-cycle issue latency).
- alu_done sampled at edge Ed → rsp_valid=1 after Ed.
- alu_start is low for ≥1 full cycle between consecutive commands. The RESP→IDLE→pop path guarantees ≥2 cycles. This guarantees the ALU and monitors see a fresh start edge.
- no_op: alu_start high for exactly 1 cycle.
- Full FIFO: cmd_ready=0; no push is possible even if a pop occurs that cycle.
- Empty FIFO in IDLE: outputs hold; no pop.
- The response path has no skid: backpressure on rsp_ready stalls issue of the next command. The FIFO keeps accepting until full.
- Timeout: alu_start high for exactly TIMEOUT cycles, then rsp_valid next cycle.

## Test plan
- Single add A=0x12, B=0x34 with the ALU raising done 3 cycles after start → alu_start high 1 cycle after accept. Response: rsp_result=0x0046, rsp_op=001, rsp_status=00.
- mad A=0xFF, B=0xFF, C=0xFF → rsp_result=0xFF00, status 00. mul A=0xFF, B=0x02 → 0x01FE.
- DEPTH=4, six back-to-back commands (add, and, xor, mul, or, mad) with the ALU stalled on done:
  - cmd_ready drops after 5 accepts (1 in flight + 4 buffered); fifo_level=4.
  - Responses arrive in order.
  - alu_start is low ≥1 cycle between each command.
- TIMEOUT=16, alu_done tied 0 → alu_start high exactly 16 cycles, then rsp_status=01, rsp_result=0. The next command issues normally.
- no_op then op 111 then add 1+1:
  - no_op → one-cycle start, no response.
  - Op 111 → response status 10 with no start.
  - add → result 0x0002.
- rsp_ready held 0 for 10 cycles after a response, plus reset asserted during WAIT of a second command:
  - Response fields stay stable until accepted.
  - Reset clears all outputs and fifo_level next edge; no stale response appears afterward.

Source files
------------

// File: rtl/tinyalu_cmd_sequencer_if.sv
// Signal bundle between a command source/response sink plus tinyALU pins and the sequencer.
// The sequencer takes the slave view; the environment driving it takes the master view.
interface tinyalu_cmd_sequencer_if #(
  parameter int DEPTH = 4
) ();
  localparam int LW = $clog2(DEPTH + 1);

  // Both streams use plain valid/ready: a transfer happens on any clock edge where
  // valid and ready are both 1; the producer holds valid and payload steady until then.
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [7:0]    cmd_a;
  logic [7:0]    cmd_b;
  logic [7:0]    cmd_c;

  logic          alu_start;
  logic [2:0]    alu_op;
  logic [7:0]    alu_a;
  logic [7:0]    alu_b;
  logic [7:0]    alu_c;
  logic          alu_done;
  logic [15:0]   alu_result;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [15:0]   rsp_result;
  logic [2:0]    rsp_op;
  logic [1:0]    rsp_status;

  logic [LW-1:0] fifo_level;
  logic [1:0]    dbg_state;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_c,
    input  alu_done, alu_result, rsp_ready,
    output cmd_ready,
    output alu_start, alu_op, alu_a, alu_b, alu_c,
    output rsp_valid, rsp_result, rsp_op, rsp_status,
    output fifo_level, dbg_state
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_c,
    output alu_done, alu_result, rsp_ready,
    input  cmd_ready,
    input  alu_start, alu_op, alu_a, alu_b, alu_c,
    input  rsp_valid, rsp_result, rsp_op, rsp_status,
    input  fifo_level, dbg_state
  );
endinterface

// File: rtl/tinyalu_cmd_sequencer.sv
// Buffers ALU commands in a FIFO, drives the tinyALU start/done protocol one command at a
// time with a done-watchdog, and returns each result (or error status) on a response stream.
module tinyalu_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  tinyalu_cmd_sequencer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NOP  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
  } cmd_t;

  localparam logic [2:0] OP_NOP     = 3'b000;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  cmd_t          head;
  cmd_t          incoming;

  state_t        state;
  logic [15:0]   wd_cnt;

  assign full          = (level == LW'(DEPTH));
  assign empty         = (level == '0);
  assign bus.cmd_ready = !full && !reset;
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign pop           = (state == S_IDLE) && !empty;
  assign head          = mem[rd_ptr];
  assign incoming      = '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b, c: bus.cmd_c};

  assign bus.fifo_level = level;
  assign bus.dbg_state  = state;

  // Storage needs no reset: occupancy is tracked by level and the pointers alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= incoming;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      wd_cnt         <= '0;
      bus.alu_start  <= 1'b0;
      bus.alu_op     <= '0;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.alu_c      <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_op     <= '0;
      bus.rsp_status <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!empty) begin
            bus.alu_op <= head.op;
            bus.alu_a  <= head.a;
            bus.alu_b  <= head.b;
            bus.alu_c  <= head.c;
            wd_cnt     <= '0;
            case (head.op)
              OP_NOP: begin
                bus.alu_start <= 1'b1;
                state         <= S_NOP;
              end
              OP_ILLEGAL: begin
                bus.rsp_valid  <= 1'b1;
                bus.rsp_op     <= head.op;
                bus.rsp_status <= 2'b10;
                bus.rsp_result <= '0;
                state          <= S_RESP;
              end
              default: begin
                bus.alu_start <= 1'b1;
                state         <= S_WAIT;
              end
            endcase
          end
        end
        S_NOP: begin
          bus.alu_start <= 1'b0;
          state         <= S_IDLE;
        end
        S_WAIT: begin
          // A done arriving on the last watchdog cycle still counts as success.
          if (bus.alu_done) begin
            bus.alu_start  <= 1'b0;
            bus.rsp_valid  <= 1'b1;
            bus.rsp_op     <= bus.alu_op;
            bus.rsp_result <= bus.alu_result;
            bus.rsp_status <= 2'b00;
            state          <= S_RESP;
          end else if (wd_cnt == 16'(TIMEOUT - 1)) begin
            bus.alu_start  <= 1'b0;
            bus.rsp_valid  <= 1'b1;
            bus.rsp_op     <= bus.alu_op;
            bus.rsp_result <= '0;
            bus.rsp_status <= 2'b01;
            state          <= S_RESP;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
        end
        S_RESP: begin
          if (bus.rsp_valid && bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tinyalu_cmd_sequencer.sv
// Bench for tinyalu_cmd_sequencer: directed vector table, fill/backpressure and reset
// sequences, then randomized traffic checked against a queue-based reference model.
module tb_tinyalu_cmd_sequencer;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tinyalu_cmd_sequencer_if #(.DEPTH(DEPTH)) bus ();

  tinyalu_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [20:0] exp_q[$];
  int          alu_delay = 3;
  int          rsp_count = 0;
  logic [20:0] last_rsp  = '0;
  int          start_rises = 0;
  logic        start_prev  = 1'b0;
  int          alu_cnt     = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Behavioural tinyALU arithmetic.
  function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic [7:0] c);
    case (op)
      3'b001:  return 16'(a) + 16'(b);
      3'b010:  return {8'h00, a & b};
      3'b011:  return {8'h00, a ^ b};
      3'b100:  return 16'(a) * 16'(b);
      3'b101:  return {8'h00, a | b};
      3'b110:  return 16'(a) * 16'(b) + 16'(c);
      default: return 16'h0000;
    endcase
  endfunction

  // Response a command must produce given how many start cycles the ALU needs for done
  // (0 = never): {status, op, result}.
  function automatic logic [20:0] expect_rsp(input logic [2:0] op, input logic [7:0] a,
                                             input logic [7:0] b, input logic [7:0] c,
                                             input int delay);
    if (op == 3'b111) return {2'b10, op, 16'h0000};
    if (delay == 0 || delay > TIMEOUT) return {2'b01, op, 16'h0000};
    return {2'b00, op, alu_fn(op, a, b, c)};
  endfunction

  // ALU model: raises done for one cycle once start has been high alu_delay cycles.
  always @(negedge clk) begin
    if (bus.alu_start) begin
      alu_cnt = alu_cnt + 1;
      if (alu_delay != 0 && alu_cnt == alu_delay) begin
        bus.alu_done   = 1'b1;
        bus.alu_result = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_c);
      end else begin
        bus.alu_done   = 1'b0;
        bus.alu_result = 16'hDEAD;
      end
    end else begin
      alu_cnt        = 0;
      bus.alu_done   = 1'b0;
      bus.alu_result = 16'hBEEF;
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.cmd_valid && bus.cmd_ready && bus.cmd_op != 3'b000)
        exp_q.push_back(expect_rsp(bus.cmd_op, bus.cmd_a, bus.cmd_b, bus.cmd_c, alu_delay));
      if (bus.rsp_valid && bus.rsp_ready) begin
        last_rsp = {bus.rsp_status, bus.rsp_op, bus.rsp_result};
        rsp_count++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rsp_unexpected: got=0x%0h expected=no response", last_rsp);
        end else begin
          logic [20:0] e;
          e = exp_q.pop_front();
          if (last_rsp !== e) begin
            bad++;
            $display("FAIL rsp_model: got=0x%0h expected=0x%0h", last_rsp, e);
          end
        end
      end
      if (bus.alu_start && !start_prev) start_rises++;
    end
    start_prev = bus.alu_start;
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the edge that accepted the command.
  task automatic send_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c);
    bit ok;
    ok = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_c = c;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("cmd_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_drained(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && bus.fifo_level == 0 && !bus.alu_start && !bus.rsp_valid) begin
        ok = 1'b1; break;
      end
    end
    check(name, 32'(ok), 32'd1);
    @(posedge clk); #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a, b, c;
    int          delay;
    bit          has_rsp;
    logic [15:0] exp_result;
    logic [1:0]  exp_status;
    int          exp_start;
  } vec_t;

  vec_t vecs[12];

  initial begin : main
    int n0, r0, run, accepts, guard;
    bit ok;
    logic [20:0] snap;
    logic [2:0]  fops[6];

    vecs[0]  = '{3'b001, 8'h12, 8'h34, 8'h00,  3, 1'b1, 16'h0046, 2'b00,  3};
    vecs[1]  = '{3'b110, 8'hFF, 8'hFF, 8'hFF,  4, 1'b1, 16'hFF00, 2'b00,  4};
    vecs[2]  = '{3'b100, 8'hFF, 8'h02, 8'h00,  2, 1'b1, 16'h01FE, 2'b00,  2};
    vecs[3]  = '{3'b010, 8'hF0, 8'h3C, 8'h00,  1, 1'b1, 16'h0030, 2'b00,  1};
    vecs[4]  = '{3'b011, 8'hF0, 8'h3C, 8'h00,  5, 1'b1, 16'h00CC, 2'b00,  5};
    vecs[5]  = '{3'b101, 8'hF0, 8'h0F, 8'h00,  2, 1'b1, 16'h00FF, 2'b00,  2};
    vecs[6]  = '{3'b001, 8'h55, 8'h66, 8'h00,  0, 1'b1, 16'h0000, 2'b01, 16};
    vecs[7]  = '{3'b001, 8'h7F, 8'h01, 8'h00, 16, 1'b1, 16'h0080, 2'b00, 16};
    vecs[8]  = '{3'b000, 8'h11, 8'h22, 8'h33,  3, 1'b0, 16'h0000, 2'b00,  1};
    vecs[9]  = '{3'b111, 8'h11, 8'h22, 8'h33,  3, 1'b1, 16'h0000, 2'b10,  0};
    vecs[10] = '{3'b001, 8'h01, 8'h01, 8'h00,  2, 1'b1, 16'h0002, 2'b00,  2};
    vecs[11] = '{3'b100, 8'h00, 8'hAB, 8'h00, 17, 1'b1, 16'h0000, 2'b01, 16};

    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_c = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_alu_start",  bus.alu_start, 0);
    check("rst_alu_op",     bus.alu_op, 0);
    check("rst_alu_abc",    {bus.alu_a, bus.alu_b, bus.alu_c}, 0);
    check("rst_rsp_valid",  bus.rsp_valid, 0);
    check("rst_rsp_fields", {bus.rsp_status, bus.rsp_op, bus.rsp_result}, 0);
    check("rst_fifo_level", bus.fifo_level, 0);
    check("rst_cmd_ready",  bus.cmd_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", bus.cmd_ready, 1);
    @(posedge clk); #1;

    // Table: one command at a time, latency, start width and response fields.
    foreach (vecs[i]) begin
      alu_delay = vecs[i].delay;
      bus.rsp_ready = 1'b1;
      n0 = rsp_count;
      send_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c);
      @(negedge clk);
      check($sformatf("v%0d_start_early", i), bus.alu_start, 0);
      run = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (k == 0) check($sformatf("v%0d_issue_latency", i), bus.alu_start, 32'(vecs[i].op != 3'b111));
        if (bus.alu_start) run++;
        else if (run > 0 || k >= 3) break;
      end
      check($sformatf("v%0d_start_cycles", i), run, vecs[i].exp_start);
      if (vecs[i].has_rsp) begin
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
          if (rsp_count != n0) begin ok = 1'b1; break; end
          @(negedge clk);
        end
        check($sformatf("v%0d_rsp_seen", i), 32'(ok), 1);
        check($sformatf("v%0d_rsp_result", i), last_rsp[15:0], vecs[i].exp_result);
        check($sformatf("v%0d_rsp_op", i), last_rsp[18:16], vecs[i].op);
        check($sformatf("v%0d_rsp_status", i), last_rsp[20:19], vecs[i].exp_status);
      end else begin
        repeat (10) @(negedge clk);
        check($sformatf("v%0d_no_rsp", i), rsp_count - n0, 0);
      end
      @(posedge clk); #1;
    end

    // Fill: six back-to-back commands, slow ALU, response stream stalled.
    fops[0] = 3'b001; fops[1] = 3'b010; fops[2] = 3'b011;
    fops[3] = 3'b100; fops[4] = 3'b101; fops[5] = 3'b110;
    alu_delay = 12;
    bus.rsp_ready = 1'b0;
    r0 = start_rises;
    accepts = 0;
    guard = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = fops[0];
    bus.cmd_a = 8'($urandom); bus.cmd_b = 8'($urandom); bus.cmd_c = 8'($urandom);
    while (accepts < 5 && guard < 40) begin
      guard++;
      @(negedge clk);
      if (bus.cmd_ready) begin
        accepts++;
        @(posedge clk); #1;
        bus.cmd_op = fops[accepts];
        bus.cmd_a = 8'($urandom); bus.cmd_b = 8'($urandom); bus.cmd_c = 8'($urandom);
      end else begin
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    check("fill_accepts", accepts, 5);
    check("fill_cmd_ready", bus.cmd_ready, 0);
    check("fill_level", bus.fifo_level, 4);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.rsp_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("bp_rsp_valid", 32'(ok), 1);
    snap = {bus.rsp_status, bus.rsp_op, bus.rsp_result};
    check("bp_first_op", snap[18:16], 3'b001);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("bp_hold_%0d", k), {bus.rsp_valid, bus.rsp_status, bus.rsp_op, bus.rsp_result},
            {1'b1, snap});
    end
    check("bp_cmd_ready_low", bus.cmd_ready, 0);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin ok = 1'b1; break; end
    end
    check("fill_sixth_accept", 32'(ok), 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    wait_drained("fill_drain");
    check("fill_start_edges", start_rises - r0, 6);

    // Reset during WAIT with another command buffered.
    alu_delay = 0;
    send_cmd(3'b001, 8'h10, 8'h20, 8'h00);
    send_cmd(3'b011, 8'hAA, 8'h55, 8'h00);
    repeat (2) @(negedge clk);
    check("pre_rst_start", bus.alu_start, 1);
    check("pre_rst_level", bus.fifo_level, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_alu_start",  bus.alu_start, 0);
    check("mid_rst_rsp_valid",  bus.rsp_valid, 0);
    check("mid_rst_level",      bus.fifo_level, 0);
    check("mid_rst_cmd_ready",  bus.cmd_ready, 0);
    check("mid_rst_outputs",    {bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_c,
                                 bus.rsp_status, bus.rsp_op, bus.rsp_result[7:0]}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    n0 = rsp_count;
    r0 = start_rises;
    repeat (30) @(negedge clk);
    check("post_rst_no_rsp",   rsp_count - n0, 0);
    check("post_rst_no_start", start_rises - r0, 0);
    check("post_rst_level",    bus.fifo_level, 0);
    @(posedge clk); #1;

    // Randomized traffic against the reference model.
    for (int round = 0; round < 6; round++) begin
      int sent;
      bit acc;
      alu_delay = $urandom_range(1, 20);
      sent = 0;
      bus.cmd_valid = 1'b0;
      for (int cyc = 0; cyc < 3000 && sent < 30; cyc++) begin
        @(negedge clk);
        acc = bus.cmd_valid && bus.cmd_ready;
        @(posedge clk); #1;
        if (acc) sent++;
        bus.rsp_ready = ($urandom_range(0, 3) != 0);
        if (acc || !bus.cmd_valid) begin
          if (sent < 30 && $urandom_range(0, 1) == 1) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_op = 3'($urandom_range(0, 7));
            bus.cmd_a = 8'($urandom); bus.cmd_b = 8'($urandom); bus.cmd_c = 8'($urandom);
          end else begin
            bus.cmd_valid = 1'b0;
          end
        end
      end
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      check($sformatf("rand%0d_sent", round), sent, 30);
      wait_drained($sformatf("rand%0d_drain", round));
    end

    check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : global_guard
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete, bad=%0d", bad);
    $fatal(1);
  end
endmodule
